// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ requesters.
// Commands are decoded into ALU control fields; illegal opcodes never reach the ALU.
//
// state | meaning
// IDLE  | waiting for a request; grants one round-robin winner
// ISSUE | ALU enabled for one cycle with decoded fields
// WAIT  | ALU result settles into C; captured at end of cycle
// RESP  | response held until rsp_ready
module alu_req_scheduler #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [4*NUM_REQ-1:0]          req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH:0]           rsp_data,
    output logic                          rsp_err,
    output logic                          alu_en,
    output logic                          alu_a_en,
    output logic                          alu_b_en,
    output logic [2:0]                    alu_a_op,
    output logic [1:0]                    alu_b_op,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    input  logic [DATA_WIDTH:0]           alu_c,
    output logic                          busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ID_WIDTH-1:0]     r_ptr;
    logic [ID_WIDTH-1:0]     r_id;
    logic [3:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH:0]     r_data;
    logic                    r_err;

    logic                    w_gnt_found;
    logic [ID_WIDTH-1:0]     w_gnt_idx;
    logic [3:0]              w_gnt_op;
    logic                    w_gnt_legal;
    logic                    w_dec_a_en;
    logic                    w_dec_b_en;
    logic [2:0]              w_dec_a_op;
    logic [1:0]              w_dec_b_op;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [ID_WIDTH-1:0] w_idx;
            w_idx = ID_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_gnt_found && req_valid[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_idx;
            end
        end
    end

    assign w_gnt_op    = req_op[4*int'(w_gnt_idx) +: 4];
    assign w_gnt_legal = (w_gnt_op <= 4'd8);

    always_comb begin
        w_dec_a_en = 1'b0;
        w_dec_b_en = 1'b0;
        w_dec_a_op = 3'd0;
        w_dec_b_op = 2'd0;
        case (r_op)
            4'd0: begin w_dec_a_en = 1'b1; w_dec_a_op = 3'd0; end
            4'd1: begin w_dec_a_en = 1'b1; w_dec_a_op = 3'd1; end
            4'd2: begin w_dec_a_en = 1'b1; w_dec_a_op = 3'd2; end
            4'd3: begin w_dec_a_en = 1'b1; w_dec_a_op = 3'd3; end
            4'd4: begin w_dec_a_en = 1'b1; w_dec_a_op = 3'd5; end
            4'd5: begin w_dec_a_en = 1'b1; w_dec_a_op = 3'd6; end
            4'd6: begin w_dec_b_en = 1'b1; w_dec_b_op = 2'd0; end
            4'd7: begin w_dec_a_en = 1'b1; w_dec_b_en = 1'b1; w_dec_b_op = 2'd2; end
            4'd8: begin w_dec_a_en = 1'b1; w_dec_b_en = 1'b1; w_dec_b_op = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_found) w_next = w_gnt_legal ? S_ISSUE : S_RESP;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= ID_WIDTH'(NUM_REQ - 1);
            r_id    <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_ptr  <= w_gnt_idx;
                        r_id   <= w_gnt_idx;
                        r_op   <= w_gnt_op;
                        r_err  <= !w_gnt_legal;
                        r_data <= '0;
                        // Operands only move for legal ops so the ALU inputs hold otherwise.
                        if (w_gnt_legal) begin
                            r_a <= req_a[DATA_WIDTH*int'(w_gnt_idx) +: DATA_WIDTH];
                            r_b <= req_b[DATA_WIDTH*int'(w_gnt_idx) +: DATA_WIDTH];
                        end
                    end
                end
                S_WAIT:  r_data <= alu_c;
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE && w_gnt_found) ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign busy      = (r_state != S_IDLE);
    assign alu_en    = (r_state == S_ISSUE);
    assign alu_a_en  = alu_en && w_dec_a_en;
    assign alu_b_en  = alu_en && w_dec_b_en;
    assign alu_a_op  = alu_en ? w_dec_a_op : 3'd0;
    assign alu_b_op  = alu_en ? w_dec_b_op : 2'd0;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed cases plus random single-requester traffic
// against an opcode-level result model; a behavioural ALU drives alu_c.
module tb_alu_req_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_op = '0;
    logic [19:0] req_a = '0;
    logic [19:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [5:0]  rsp_data;
    logic        rsp_err;
    logic        alu_en, alu_a_en, alu_b_en;
    logic [2:0]  alu_a_op;
    logic [1:0]  alu_b_op;
    logic [4:0]  alu_a, alu_b;
    logic [5:0]  alu_c = '0;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;

    alu_req_scheduler #(.DATA_WIDTH(5), .NUM_REQ(4), .ID_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_en(alu_en), .alu_a_en(alu_a_en), .alu_b_en(alu_b_en),
        .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: interprets the control fields, registers C when enabled.
    function automatic logic [5:0] alu_fn(logic ae, logic be, logic [2:0] aop,
                                          logic [1:0] bop, logic [4:0] a, logic [4:0] b);
        logic [5:0] sa, sb;
        sa = {a[4], a};
        sb = {b[4], b};
        if (ae && !be) begin
            case (aop)
                3'd0: return sa + sb;
                3'd1: return sa - sb;
                3'd2: return {1'b0, a ^ b};
                3'd3: return {1'b0, a & b};
                3'd5: return {1'b0, a | b};
                3'd6: return {1'b0, ~(a ^ b)};
                default: return 6'bx;
            endcase
        end else if (!ae && be && bop == 2'd0) return {1'b0, ~(a & b)};
        else if (ae && be && bop == 2'd2) return sa - 6'd1;
        else if (ae && be && bop == 2'd3) return sb + 6'd2;
        return 6'bx;
    endfunction

    always @(posedge clk)
        if (alu_en) alu_c <= alu_fn(alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_a, alu_b);

    // Expected result straight from the opcode meaning.
    function automatic logic [5:0] ref_result(int op, logic [4:0] a, logic [4:0] b);
        int ia, ib;
        logic [5:0] r;
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            0: r = 6'(ia + ib);
            1: r = 6'(ia - ib);
            2: r = {1'b0, a ^ b};
            3: r = {1'b0, a & b};
            4: r = {1'b0, a | b};
            5: r = {1'b0, ~(a ^ b)};
            6: r = {1'b0, ~(a & b)};
            7: r = 6'(ia - 1);
            8: r = 6'(ib + 2);
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // {a_en, b_en, a_op, b_op} per legal opcode
    logic [6:0] ctl_tab [0:8] = '{7'b1_0_000_00, 7'b1_0_001_00, 7'b1_0_010_00,
                                  7'b1_0_011_00, 7'b1_0_101_00, 7'b1_0_110_00,
                                  7'b0_1_000_00, 7'b1_1_000_10, 7'b1_1_000_11};

    function automatic int next_in(int from, logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called between a negedge and the following posedge.
    task automatic run_cmd(input string tag, input int id, input int op, input logic [4:0] a,
                           input logic [4:0] b, input int bp, input logic [3:0] others);
        logic       legal;
        int         pulses, lat;
        logic [5:0] expd;
        legal  = (op <= 8);
        pulses = 0;
        lat    = 0;
        expd   = ref_result(op, a, b);
        rsp_ready = (bp == 0);
        req_op[id*4 +: 4] = 4'(op);
        req_a[id*5 +: 5]  = a;
        req_b[id*5 +: 5]  = b;
        req_valid[id]     = 1'b1;
        req_valid         = req_valid | others;
        #1;
        for (int w = 0; w < 40 && req_ready == 4'd0; w++) begin
            cyc();
            @(negedge clk);
        end
        chk({tag, ".grant"}, req_ready, 32'd1 << id);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 1) req_valid[id] = 1'b0;
            @(negedge clk);
            if (alu_en) begin
                pulses++;
                if (legal) chk({tag, ".ctl"}, {alu_a_en, alu_b_en, alu_a_op, alu_b_op}, ctl_tab[op]);
                chk({tag, ".alu_ab"}, {alu_a, alu_b}, {a, b});
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".latency"}, lat, legal ? 3 : 1);
        chk({tag, ".pulses"}, pulses, legal ? 1 : 0);
        chk({tag, ".rsp"}, {rsp_id, rsp_err, rsp_data}, {2'(id), !legal, expd});
        if (bp > 0) begin
            repeat (bp - 1) begin
                cyc();
                @(negedge clk);
                chk({tag, ".hold"}, {rsp_valid, rsp_data, req_ready}, {1'b1, expd, 4'd0});
            end
            cyc();
            rsp_ready = 1'b1;
            @(negedge clk);
            chk({tag, ".hold_last"}, {rsp_valid, rsp_data, req_ready}, {1'b1, expd, 4'd0});
        end
        cyc();
        @(negedge clk);
        chk({tag, ".done"}, {rsp_valid, busy}, 2'b00);
        if (others != 4'd0) chk({tag, ".next_grant"}, req_ready, 32'd1 << next_in(id, others));
    endtask

    int         acc_cyc[$], acc_id[$], rsp_ids[$];
    logic [5:0] rsp_vals[$];
    logic [4:0] rr_a [4];
    logic [4:0] rr_b [4];

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.hold", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy}, 0);
        chk("rst.alu", {alu_en, alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_a, alu_b}, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst.release", {rsp_valid, busy, alu_en}, 0);

        // Round-robin with all requesters continuously valid
        for (int i = 0; i < 4; i++) begin
            rr_a[i] = 5'($urandom);
            rr_b[i] = 5'($urandom);
            req_op[i*4 +: 4] = 4'd0;
            req_a[i*5 +: 5]  = rr_a[i];
            req_b[i*5 +: 5]  = rr_b[i];
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 60 && rsp_ids.size() < 5; c++) begin
            if (c > 0) begin
                cyc();
                if (acc_id.size() >= 5) req_valid = 4'h0;
                @(negedge clk);
            end
            if (req_ready != 4'd0) begin
                acc_cyc.push_back(c);
                acc_id.push_back($clog2(int'(req_ready)));
            end
            if (rsp_valid) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_vals.push_back(rsp_data);
            end
        end
        req_valid = 4'h0;
        chk("rr.count", {acc_id.size(), rsp_ids.size()}, {32'd5, 32'd5});
        for (int i = 0; i < 5 && i < acc_id.size() && i < rsp_ids.size(); i++) begin
            chk($sformatf("rr.grant%0d", i), acc_id[i], i % 4);
            chk($sformatf("rr.rsp_id%0d", i), rsp_ids[i], i % 4);
            chk($sformatf("rr.data%0d", i), rsp_vals[i], ref_result(0, rr_a[i % 4], rr_b[i % 4]));
            if (i > 0) chk($sformatf("rr.spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 4);
        end
        for (int w = 0; w < 20 && busy; w++) begin
            cyc();
            @(negedge clk);
        end
        chk("rr.idle", busy, 0);

        // Directed opcodes
        run_cmd("add", 0, 0, 5'd7, 5'd3, 0, 4'd0);
        run_cmd("nand", 2, 6, 5'b10101, 5'b01111, 0, 4'd0);
        chk("nand.value", rsp_vals.size() > 0 ? ref_result(6, 5'b10101, 5'b01111) : 6'd0, 6'd26);
        run_cmd("dec_a", 2, 7, 5'b10000, 5'($urandom), 0, 4'd0);
        run_cmd("illegal", 1, 12, 5'd9, 5'd4, 0, 4'd0);

        // Backpressure with requester 0 waiting
        req_op[3:0] = 4'd0;
        req_a[4:0]  = 5'd1;
        req_b[4:0]  = 5'd1;
        run_cmd("bp_sub", 3, 1, 5'd2, 5'd5, 5, 4'b0001);
        run_cmd("bp_next", 0, 0, 5'd1, 5'd1, 0, 4'd0);

        // Random single-requester traffic including illegal opcodes
        for (int t = 0; t < 40; t++)
            run_cmd($sformatf("rnd%0d", t), int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                    5'($urandom), 5'($urandom), int'($urandom_range(2, 0)), 4'd0);

        // Reset during WAIT drops the command
        req_op[11:8] = 4'd0;
        req_a[14:10] = 5'd4;
        req_b[14:10] = 5'd4;
        req_valid[2] = 1'b1;
        #1;
        chk("mid.grant", req_ready, 4'b0100);
        cyc();
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("mid.issue", alu_en, 1);
        cyc();
        @(negedge clk);
        chk("mid.wait", {busy, alu_en, rsp_valid}, 3'b100);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid.rst_out", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy}, 0);
        chk("mid.rst_alu", {alu_en, alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_a, alu_b}, 0);
        repeat (4) begin
            cyc();
            @(negedge clk);
            chk("mid.no_rsp", {rsp_valid, busy}, 2'b00);
        end
        req_op[15:12] = 4'd8;
        req_a[19:15]  = 5'd3;
        req_b[19:15]  = 5'd6;
        run_cmd("post_rst0", 0, 1, 5'd9, 5'd2, 0, 4'b1000);
        run_cmd("post_rst3", 3, 8, 5'd3, 5'd6, 0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Round-robin scheduler that shares one ALU instance (registered signed output C, controlled by ALU_en/a_en/b_en/a_op/b_op) between NUM_REQ requesters.
- Each requester issues a command with a unified opcode and operands over a valid/ready handshake.
- The block decodes the opcode into ALU control fields, pulses the ALU for one cycle, captures C, and returns the result tagged with the requester id.
- Opcodes the ALU treats as illegal are never driven to it.

Parameters:
DATA_WIDTH, 5, operand width; result width is DATA_WIDTH+1
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of rsp_id; must be at least $clog2(NUM_REQ)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  one-hot accept pulse to the granted requester
req_op  in  4*NUM_REQ  unified opcode, slice i belongs to requester i
req_a  in  DATA_WIDTH*NUM_REQ  signed operand A per requester
req_b  in  DATA_WIDTH*NUM_REQ  signed operand B per requester
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_id  out  ID_WIDTH  requester index for the response
rsp_data  out  DATA_WIDTH+1  signed result
rsp_err  out  1  illegal opcode flag
alu_en, alu_a_en, alu_b_en  out  1 each  ALU enables
alu_a_op  out  3  ALU a_op field
alu_b_op  out  2  ALU b_op field
alu_a, alu_b  out  DATA_WIDTH each  ALU operands
alu_c  in  DATA_WIDTH+1  ALU registered result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Round-robin pointer is set so requester 0 has highest priority.
  - Reset mid-operation drops the in-flight command with no response; rst overrides everything.
- Opcode decode, written as a_en/b_en/a_op/b_op:
  - 0 ADD = 1/0/0/x
  - 1 SUB = 1/0/1/x
  - 2 XOR = 1/0/2/x
  - 3 AND = 1/0/3/x
  - 4 OR = 1/0/5/x
  - 5 XNOR = 1/0/6/x
  - 6 NAND = 0/1/x/0
  - 7 DEC_A (A-1) = 1/1/x/2
  - 8 INC2_B (B+2) = 1/1/x/3
  - 9..15 are illegal.
  - Don't-care fields are driven to 0.
- States:
  - IDLE:
    - If any req_valid, grant the first valid index at or after pointer+1 (mod NUM_REQ).
    - req_ready[grant]=1 for this cycle only; latch op, A, B and id.
    - Pointer becomes grant.
    - Legal op goes to ISSUE; illegal op goes to RESP with err=1, data=0.
  - ISSUE (1 cycle):
    - alu_en=1 with decoded fields and latched operands.
    - Go to WAIT.
  - WAIT (1 cycle):
    - alu_en=0; capture alu_c into rsp_data at the end of the cycle.
    - Go to RESP.
  - RESP:
    - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
    - On rsp_valid&&rsp_ready go to IDLE, and clear rsp_valid on the next cycle.
- ALU signals outside ISSUE:
  - alu_en, enables and op fields are 0.
  - alu_a and alu_b hold their last values; the ALU holds C while disabled.
- Latency:
  - Legal op: rsp_valid asserts 3 cycles after the accept cycle.
  - Illegal op: rsp_valid asserts 1 cycle after the accept cycle.
  - Minimum spacing between accepts is 4 cycles (legal) or 2 cycles (illegal), given rsp_ready=1.
- Grant rules:
  - No new grant while busy; req_valid is sampled only in IDLE.
  - A requester must hold valid and its data until it sees req_ready.
- Arithmetic is performed by the ALU; this block does not modify alu_c.

Test Plan:
- ADD, single requester: requester 0, op=0, A=7, B=3, rsp_ready=1. Required: alu_en pulses once with a_en=1, b_en=0, a_op=0; rsp_valid 3 cycles after req_ready[0]; rsp_data=10, rsp_id=0, rsp_err=0.
- NAND and DEC_A: requester 2 sends op=6 with A=5'b10101, B=5'b01111, then op=7 with A=-16. Required: rsp_data=6'b011010 (26) with a_en=0, b_en=1, b_op=0; then rsp_data=-17 (6'b101111) with a_en=b_en=1, b_op=2.
- Round-robin: all 4 requesters hold req_valid with op=0 continuously. Required: grant order is 0,1,2,3,0; each accept is 4 cycles apart; rsp_id matches the grant order.
- Illegal opcode: requester 1, op=12. Required: alu_en stays 0; rsp_valid 1 cycle after accept with rsp_err=1, rsp_data=0, rsp_id=1.
- Backpressure: after SUB with A=2, B=5, hold rsp_ready=0 for 5 cycles. Required: rsp_valid=1 and rsp_data=-3 stay stable; req_ready stays 0 for other valid requesters; grant follows the cycle after rsp_ready=1.
- Reset mid-operation: assert rst during WAIT. Required: next cycle all outputs are 0, busy=0, no response for the dropped command; requester 0 has priority after reset.
